// File: rtl/swap_ctrl.sv
// swap_ctrl: arbitrates a single-read/single-write register file between a host
// port and a swap-request port. A swap of A and B runs as read A -> copy B to A
// -> write tmp to B, then returns to IDLE with a one-cycle swap_done pulse.
module swap_ctrl #(
    parameter int ADDR_width = 7,
    parameter int DATA_width = 8,
    parameter int CNT_width  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_we,
    input  logic [ADDR_width-1:0] host_addr_w,
    input  logic [DATA_width-1:0] host_data_w,
    output logic                  host_wready,
    input  logic [ADDR_width-1:0] host_addr_r,
    output logic [DATA_width-1:0] host_data_r,
    output logic                  host_rvalid,
    input  logic                  swap_valid,
    input  logic [ADDR_width-1:0] swap_addr_A,
    input  logic [ADDR_width-1:0] swap_addr_B,
    output logic                  swap_ready,
    output logic                  swap_done,
    output logic                  busy,
    output logic [CNT_width-1:0]  swap_count,
    output logic                  rf_we,
    output logic [ADDR_width-1:0] rf_addr_r,
    output logic [ADDR_width-1:0] rf_addr_w,
    output logic [DATA_width-1:0] rf_data_w,
    input  logic [DATA_width-1:0] rf_data_r
);

    typedef enum logic [1:0] {IDLE, RD_A, CPY, WR_B} state_t;

    state_t                state, state_nxt;
    logic [DATA_width-1:0] tmp;
    logic [ADDR_width-1:0] addr_a, addr_b;
    logic                  swap_acc;
    logic                  swap_fin;

    localparam logic [CNT_width-1:0] CNT_ONE = {{(CNT_width-1){1'b0}}, 1'b1};

    // A swap is taken only in IDLE; a degenerate A==B swap completes on the spot.
    assign swap_acc = (state == IDLE) && swap_valid;
    assign swap_fin = (swap_acc && (swap_addr_A == swap_addr_B)) || (state == WR_B);

    // Host read data is the file's combinational read; only meaningful in IDLE.
    assign host_data_r = rf_data_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and file-port muxing; host inputs drive the write path by default
    // so the file ports never float to X.
    always_comb begin
        state_nxt   = state;
        host_wready = 1'b0;
        swap_ready  = 1'b0;
        busy        = 1'b1;
        host_rvalid = 1'b0;
        rf_we       = 1'b0;
        rf_addr_r   = host_addr_r;
        rf_addr_w   = host_addr_w;
        rf_data_w   = host_data_w;
        case (state)
            IDLE: begin
                host_wready = 1'b1;
                swap_ready  = 1'b1;
                busy        = 1'b0;
                host_rvalid = 1'b1;
                rf_we       = host_we;
                if (swap_valid && (swap_addr_A != swap_addr_B)) state_nxt = RD_A;
            end
            RD_A: begin
                rf_addr_r = addr_a;
                state_nxt = CPY;
            end
            CPY: begin
                rf_addr_r = addr_b;
                rf_we     = 1'b1;
                rf_addr_w = addr_a;
                rf_data_w = rf_data_r;
                state_nxt = WR_B;
            end
            WR_B: begin
                rf_we     = 1'b1;
                rf_addr_w = addr_b;
                rf_data_w = tmp;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Swap operand latch, temp capture of A, completion pulse and saturating count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_a     <= '0;
            addr_b     <= '0;
            tmp        <= '0;
            swap_done  <= 1'b0;
            swap_count <= '0;
        end else begin
            swap_done <= swap_fin;
            if (swap_acc) begin
                addr_a <= swap_addr_A;
                addr_b <= swap_addr_B;
            end
            if (state == RD_A) tmp <= rf_data_r;
            if (swap_fin && (swap_count != {CNT_width{1'b1}}))
                swap_count <= swap_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_swap_ctrl.sv
// Bench for swap_ctrl: directed scenarios plus random host/swap traffic, checked
// against a transaction-level model (array of file contents, swap counts).
module tb_swap_ctrl;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int CW2 = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr_w = '0;
    logic [DW-1:0] host_data_w = '0;
    logic [AW-1:0] host_addr_r = '0;
    logic          swap_valid = 1'b0;
    logic [AW-1:0] swap_addr_A = '0;
    logic [AW-1:0] swap_addr_B = '0;
    logic          host_wready, host_rvalid, swap_ready, swap_done, busy, rf_we;
    logic [DW-1:0] host_data_r, rf_data_w, rf_data_r;
    logic [AW-1:0] rf_addr_r, rf_addr_w;
    logic [CW-1:0] swap_count;

    // Second instance with a narrow counter so saturation is reachable quickly.
    logic           host_wready2, host_rvalid2, swap_ready2, swap_done2, busy2, rf_we2;
    logic [DW-1:0]  host_data_r2, rf_data_w2;
    logic [DW-1:0]  zero_d = '0;
    logic [AW-1:0]  rf_addr_r2, rf_addr_w2;
    logic [CW2-1:0] swap_count2;

    logic [DW-1:0] mem     [128] = '{default: '0};
    logic [DW-1:0] ref_mem [128] = '{default: '0};
    int checks = 0, errors = 0;
    int wr_cnt = 0, hit_cnt = 0;
    int ref_cnt = 0, ref_cnt2 = 0;
    logic [AW-1:0] mon_addr = '0;
    logic [DW-1:0] mon_data = '0;

    swap_ctrl #(.ADDR_width(AW), .DATA_width(DW), .CNT_width(CW)) dut (
        .clk(clk), .reset(reset),
        .host_we(host_we), .host_addr_w(host_addr_w), .host_data_w(host_data_w),
        .host_wready(host_wready), .host_addr_r(host_addr_r), .host_data_r(host_data_r),
        .host_rvalid(host_rvalid), .swap_valid(swap_valid), .swap_addr_A(swap_addr_A),
        .swap_addr_B(swap_addr_B), .swap_ready(swap_ready), .swap_done(swap_done),
        .busy(busy), .swap_count(swap_count), .rf_we(rf_we), .rf_addr_r(rf_addr_r),
        .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .rf_data_r(rf_data_r)
    );

    swap_ctrl #(.ADDR_width(AW), .DATA_width(DW), .CNT_width(CW2)) dut2 (
        .clk(clk), .reset(reset),
        .host_we(host_we), .host_addr_w(host_addr_w), .host_data_w(host_data_w),
        .host_wready(host_wready2), .host_addr_r(host_addr_r), .host_data_r(host_data_r2),
        .host_rvalid(host_rvalid2), .swap_valid(swap_valid), .swap_addr_A(swap_addr_A),
        .swap_addr_B(swap_addr_B), .swap_ready(swap_ready2), .swap_done(swap_done2),
        .busy(busy2), .swap_count(swap_count2), .rf_we(rf_we2), .rf_addr_r(rf_addr_r2),
        .rf_addr_w(rf_addr_w2), .rf_data_w(rf_data_w2), .rf_data_r(zero_d)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, clocked write, plus write monitors.
    assign rf_data_r = mem[rf_addr_r];
    always @(posedge clk) begin
        if (rf_we) begin
            mem[rf_addr_w] <= rf_data_w;
            wr_cnt <= wr_cnt + 1;
            if (rf_addr_w == mon_addr && rf_data_w == mon_data) hit_cnt <= hit_cnt + 1;
        end
    end

    function automatic int sat(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ref_swap(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [DW-1:0] t;
        t = ref_mem[a]; ref_mem[a] = ref_mem[b]; ref_mem[b] = t;
        ref_cnt  = sat(ref_cnt, CW);
        ref_cnt2 = sat(ref_cnt2, CW2);
    endtask

    // Called at a negedge; returns at a negedge once the write has committed.
    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        host_we = 1'b1; host_addr_w = a; host_data_w = d;
        while (!host_wready && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) chk("wr_timeout", 1, 0);
        @(negedge clk);
        host_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a);
        host_addr_r = a;
        #1;
        chk(tag, host_data_r, ref_mem[a]);
    endtask

    // Full swap with optional same-cycle host write; checks latency, busy length,
    // counts and the single-cycle done pulse.
    task automatic do_swap(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int n = 0, busy_cyc = 0;
        swap_valid = 1'b1; swap_addr_A = a; swap_addr_B = b;
        if (wr) begin host_we = 1'b1; host_addr_w = wa; host_data_w = wd; end
        while (!swap_ready && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) chk("swap_accept_timeout", 1, 0);
        @(negedge clk);
        swap_valid = 1'b0; host_we = 1'b0;
        if (wr) ref_mem[wa] = wd;
        ref_swap(a, b);
        n = 0;
        while (!swap_done && n < 8) begin
            if (busy) busy_cyc++;
            @(negedge clk); n++;
        end
        chk("swap_lat", n, (a == b) ? 0 : 3);
        chk("swap_busy", busy_cyc, (a == b) ? 0 : 3);
        chk("swap_cnt", swap_count, ref_cnt);
        chk("swap_cnt_sat", swap_count2, ref_cnt2);
        chk("swap_idle_after", busy, 0);
        @(negedge clk);
        chk("swap_done_pulse", swap_done, 0);
    endtask

    initial begin
        int w0, h0, n;
        logic [AW-1:0] ra, rb;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", swap_done, 0);
        chk("rst_cnt", swap_count, 0);
        chk("rst_sready", swap_ready, 1);
        chk("rst_wready", host_wready, 1);
        chk("rst_rfwe", rf_we, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: basic swap
        host_write(3, 8'h11);
        host_write(9, 8'h22);
        do_swap(3, 9, 0, 0, 0);
        host_addr_r = 3; #1;
        chk("t1_m3", host_data_r, 8'h22);
        chk("t1_rvalid", host_rvalid, 1);
        host_addr_r = 9; #1;
        chk("t1_m9", host_data_r, 8'h11);
        chk("t1_cnt", swap_count, 1);

        // 2: A==B swap writes nothing
        @(negedge clk);
        host_write(5, 8'h7E);
        w0 = wr_cnt;
        do_swap(5, 5, 0, 0, 0);
        chk("t2_nowr", wr_cnt - w0, 0);
        read_chk("t2_m5", 5);

        // 3: same-cycle host write and swap accept
        @(negedge clk);
        host_write(4, 8'h66);
        do_swap(3, 4, 1, 3, 8'h55);
        host_addr_r = 3; #1; chk("t3_m3", host_data_r, 8'h66);
        host_addr_r = 4; #1; chk("t3_m4", host_data_r, 8'h55);

        // 4: host write held across a swap
        @(negedge clk);
        host_write(20, 8'hA1);
        host_write(21, 8'hB2);
        mon_addr = 30; mon_data = 8'hC3;
        w0 = wr_cnt; h0 = hit_cnt;
        swap_valid = 1'b1; swap_addr_A = 20; swap_addr_B = 21;
        @(negedge clk);
        swap_valid = 1'b0;
        host_we = 1'b1; host_addr_w = 30; host_data_w = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            chk("t4_wready_lo", host_wready, 0);
            @(negedge clk);
        end
        chk("t4_done", swap_done, 1);
        chk("t4_wready_hi", host_wready, 1);
        @(negedge clk);
        host_we = 1'b0;
        ref_swap(20, 21);
        ref_mem[30] = 8'hC3;
        chk("t4_wrcnt", wr_cnt - w0, 3);
        chk("t4_hits", hit_cnt - h0, 1);
        read_chk("t4_m20", 20);
        read_chk("t4_m21", 21);
        read_chk("t4_m30", 30);

        // 5: back-to-back swaps with swap_valid held
        @(negedge clk);
        swap_valid = 1'b1; swap_addr_A = 3; swap_addr_B = 9;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("t5_rdy_lo", swap_ready, 0);
            @(negedge clk);
        end
        chk("t5_done1", swap_done, 1);
        chk("t5_rdy_hi", swap_ready, 1);
        swap_addr_A = 9; swap_addr_B = 1;
        ref_swap(3, 9);
        @(negedge clk);
        chk("t5_nogap", busy, 1);
        swap_valid = 1'b0;
        ref_swap(9, 1);
        n = 0;
        while (!swap_done && n < 8) begin @(negedge clk); n++; end
        chk("t5_lat2", n, 3);
        chk("t5_cnt", swap_count, ref_cnt);
        read_chk("t5_m3", 3);
        read_chk("t5_m9", 9);
        read_chk("t5_m1", 1);

        // 6: reset while in CPY
        @(negedge clk);
        host_write(10, 8'h3C);
        host_write(11, 8'hC3);
        swap_valid = 1'b1; swap_addr_A = 10; swap_addr_B = 11;
        @(negedge clk);
        swap_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cnt", swap_count, 0);
        chk("t6_done", swap_done, 0);
        ref_cnt = 0; ref_cnt2 = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_nodone", swap_done, 0);
        end
        read_chk("t6_m10", 10);
        read_chk("t6_m11", 11);
        @(negedge clk);
        do_swap(10, 11, 0, 0, 0);
        read_chk("t6_m10s", 10);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ra = AW'($urandom_range(0, 127));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0: host_write(ra, DW'($urandom));
                1: do_swap(ra, rb, 0, 0, 0);
                2: do_swap(ra, rb, 1, AW'($urandom_range(0, 127)), DW'($urandom));
                default: read_chk("rnd_rd", ra);
            endcase
        end
        @(negedge clk);
        for (int i = 0; i < 128; i++) chk("mem_final", mem[i], ref_mem[i]);

        // 7: saturation on the narrow-counter instance
        for (int i = 0; i < 9; i++) do_swap(7, 7, 0, 0, 0);
        do_swap(12, 13, 0, 0, 0);
        chk("t7_sat", swap_count2, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
